pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline sequencer for the IF/ID/EX/WB core around the instruction decoder.
//  Issues PC and pipeline-register enables and flushes, and produces the
//  "previous instruction was branch" flag that the decoder consumes.
//  Handles three cases: taken branches (squash wrong-path slots), load-use
//  hazards (insert a bubble) and multi-cycle memory access (req/ack freeze).
//  Also keeps a saturating stall-cycle counter for performance monitoring.
// PARAMETERS
//  REGAW     4   register address width
//  BR_FLUSH  1   wrong-path slots squashed after a taken branch (1..3)
//  CNTW      16  stall counter width
// PORTS
//  clk              in   1      clock, rising edge
//  rst_n            in   1      asynchronous active-low reset
//  id_valid_in      in   1      ID stage holds a real (non-bubble) instruction
//  id_rn_in         in   REGAW  Rn of the ID instruction
//  id_rm_in         in   REGAW  Rm of the ID instruction
//  id_uses_rn_in    in   1      ID instruction reads Rn
//  id_uses_rm_in    in   1      ID instruction reads Rm (not an immediate/bypass)
//  id_rd_in         in   REGAW  Rd of the ID instruction
//  id_is_load_in    in   1      ID instruction is a load whose condition passed
//  id_mem_op_in     in   1      ID instruction is a load or store whose condition passed
//  id_ib_in         in   1      ID instruction is a taken branch (decoder ib)
//  mem_ack_in       in   1      data memory completes the current request
//  pc_we_out        out  1      PC register update enable
//  pc_sel_br_out    out  1      1: PC loads branch target, 0: PC+4
//  ifid_we_out      out  1      IF/ID register load enable
//  ifid_flush_out   out  1      IF/ID loads a bubble (takes priority over we)
//  idex_we_out      out  1      ID/EX register load enable
//  idex_flush_out   out  1      ID/EX loads a bubble
//  mem_req_out      out  1      memory request for the EX-stage load/store
//  ispb_out         out  1      to decoder ispb_in: ID slot is wrong-path
//  stall_cnt_out    out  CNTW   saturating count of stall/freeze cycles
// BEHAVIOUR
//  Reset: state RUN; ex_load_v, ex_mem_v and ex_rd cleared; all outputs 0.
//   pc_we_out goes to 1 in the first cycle after rst_n deasserts.
//  EX tracking (updated on every edge where idex_we_out=1):
//   ex_load_v <= id_valid & id_is_load & ~idex_flush
//   ex_mem_v  <= id_valid & id_mem_op  & ~idex_flush
//   ex_rd     <= id_rd
//  mem_req_out = ex_mem_v (combinational). Held high until mem_ack_in=1.
//  Hazard (combinational):
//   lu = id_valid & ex_load_v & ((uses_rn & rn==ex_rd) | (uses_rm & rm==ex_rd))
//  FSM states: RUN, FLUSH, MEM_WAIT. Priority: memory > branch > load-use.
//  RUN:
//   - ex_mem_v & ~mem_ack: freeze. pc/ifid/idex we = 0 and no flush.
//     Go to MEM_WAIT. A branch or hazard in ID is re-evaluated after the ack.
//   - else if id_ib & id_valid: pc_we=1, pc_sel_br=1, ifid_flush=1,
//     idex_we=1. ispb_out=1 in the next cycle.
//     If BR_FLUSH>1, go to FLUSH with cnt=BR_FLUSH-1.
//   - else if lu: pc_we=0, ifid_we=0, idex_we=1 with idex_flush=1
//     (one bubble). The hazard clears next cycle because ex_load_v=0.
//   - else: pc_we=ifid_we=idex_we=1.
//  FLUSH: ifid_flush=1, pc_we=ifid_we=idex_we=1, ispb_out=1, cnt--.
//   Return to RUN when cnt reaches 0. A memory stall in FLUSH freezes and
//   holds cnt, then resumes FLUSH (not RUN) after the ack.
//  MEM_WAIT: all enables 0 and mem_req_out=1. On mem_ack_in, release in the
//   same cycle (enables evaluated as in RUN with ex_mem_v treated as
//   complete) and return to the saved state (RUN or FLUSH).
//  ispb_out is registered and stays 1 for exactly BR_FLUSH cycles per branch.
//  stall_cnt_out increments each cycle with pc_we_out=0 after reset release.
//   It saturates at all-ones and never wraps.
//  A zero-wait memory (ack in the same cycle as req) causes no stall.
//  Reset asserted mid-MEM_WAIT or mid-FLUSH: immediate return to reset
//   values; the outstanding request is abandoned.
// TESTING
//  1 Straight-line ALU ops, no hazards -> pc_we/ifid_we/idex_we=1 every
//    cycle, stall_cnt=0.
//  2 LDR r3 then ADD r1,r3,r2 -> one cycle pc_we=0, idex_flush=1, then
//    resume; stall_cnt=1. Same with ADD using r4 -> no stall.
//  3 Taken branch in ID (BR_FLUSH=1) -> pc_sel_br=1, ifid_flush=1 that
//    cycle; ispb_out=1 next cycle only. With BR_FLUSH=3 -> ispb high 3 cycles.
//  4 STR in EX with ack delayed 3 cycles -> mem_req held 4 cycles, all
//    enables 0 for 3, stall_cnt=3. Branch in ID during the wait is taken
//    in the ack cycle.
//  5 rst_n pulsed low during MEM_WAIT -> outputs 0 asynchronously,
//    mem_req_out=0, state RUN after release.
//  6 Force 2^CNTW+5 stall cycles -> stall_cnt_out holds 0xFFFF.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline sequencer and the ID stage / data memory.
interface pipe_ctrl_if #(
  parameter int unsigned REGAW = 4,
  parameter int unsigned CNTW  = 16
);
  // ID-stage instruction attributes and memory ack
  logic             id_valid_in;
  logic [REGAW-1:0] id_rn_in;
  logic [REGAW-1:0] id_rm_in;
  logic             id_uses_rn_in;
  logic             id_uses_rm_in;
  logic [REGAW-1:0] id_rd_in;
  logic             id_is_load_in;
  logic             id_mem_op_in;
  logic             id_ib_in;
  logic             mem_ack_in;
  // Pipeline control and monitoring outputs
  logic             pc_we_out;
  logic             pc_sel_br_out;
  logic             ifid_we_out;
  logic             ifid_flush_out;
  logic             idex_we_out;
  logic             idex_flush_out;
  logic             mem_req_out;
  logic             ispb_out;
  logic [CNTW-1:0]  stall_cnt_out;

  modport master (
    output id_valid_in, id_rn_in, id_rm_in, id_uses_rn_in, id_uses_rm_in, id_rd_in,
    output id_is_load_in, id_mem_op_in, id_ib_in, mem_ack_in,
    input  pc_we_out, pc_sel_br_out, ifid_we_out, ifid_flush_out, idex_we_out,
    input  idex_flush_out, mem_req_out, ispb_out, stall_cnt_out
  );

  modport slave (
    input  id_valid_in, id_rn_in, id_rm_in, id_uses_rn_in, id_uses_rm_in, id_rd_in,
    input  id_is_load_in, id_mem_op_in, id_ib_in, mem_ack_in,
    output pc_we_out, pc_sel_br_out, ifid_we_out, ifid_flush_out, idex_we_out,
    output idex_flush_out, mem_req_out, ispb_out, stall_cnt_out
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the IF/ID/EX/WB core: PC / pipeline-register enables and
// flushes for taken branches, load-use bubbles and multi-cycle memory freezes, plus a
// saturating stall-cycle counter.
module pipe_ctrl #(
  parameter int unsigned REGAW    = 4,
  parameter int unsigned BR_FLUSH = 1,
  parameter int unsigned CNTW     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StRun, StFlush, StMemWait} state_e;

  state_e           st_q, st_d;
  state_e           ret_q, ret_d;   // state to resume once the memory ack arrives
  state_e           eff;
  logic [1:0]       cnt_q, cnt_d;
  logic             ex_load_v_q;
  logic             ex_mem_v_q;
  logic [REGAW-1:0] ex_rd_q;
  logic             ispb_q;
  logic [CNTW-1:0]  stall_cnt_q;

  logic busy;
  logic lu;
  logic pc_we, pc_sel_br, ifid_we, ifid_flush, idex_we, idex_flush;

  // Load-use hazard against the load currently in EX
  always_comb begin
    lu = bus.id_valid_in & ex_load_v_q &
         ((bus.id_uses_rn_in & (bus.id_rn_in == ex_rd_q)) |
          (bus.id_uses_rm_in & (bus.id_rm_in == ex_rd_q)));
  end

  // Next-state and enable decode; MEM_WAIT behaves as its saved state once acked
  always_comb begin
    st_d       = st_q;
    ret_d      = ret_q;
    cnt_d      = cnt_q;
    pc_we      = 1'b0;
    pc_sel_br  = 1'b0;
    ifid_we    = 1'b0;
    ifid_flush = 1'b0;
    idex_we    = 1'b0;
    idex_flush = 1'b0;
    busy       = ex_mem_v_q & ~bus.mem_ack_in;
    eff        = (st_q == StMemWait) ? ret_q : st_q;

    if (busy) begin
      st_d  = StMemWait;
      ret_d = eff;
    end else if (eff == StFlush) begin
      pc_we      = 1'b1;
      ifid_we    = 1'b1;
      ifid_flush = 1'b1;
      idex_we    = 1'b1;
      cnt_d      = cnt_q - 2'd1;
      st_d       = (cnt_q == 2'd1) ? StRun : StFlush;
    end else begin
      st_d = StRun;
      if (bus.id_ib_in & bus.id_valid_in) begin
        pc_we      = 1'b1;
        pc_sel_br  = 1'b1;
        ifid_flush = 1'b1;
        idex_we    = 1'b1;
        if (BR_FLUSH > 1) begin
          st_d  = StFlush;
          cnt_d = 2'(BR_FLUSH - 1);
        end
      end else if (lu) begin
        idex_we    = 1'b1;
        idex_flush = 1'b1;
      end else begin
        pc_we   = 1'b1;
        ifid_we = 1'b1;
        idex_we = 1'b1;
      end
    end
  end

  // State, EX-slot tracking, wrong-path flag and stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= StRun;
      ret_q       <= StRun;
      cnt_q       <= 2'd0;
      ex_load_v_q <= 1'b0;
      ex_mem_v_q  <= 1'b0;
      ex_rd_q     <= '0;
      ispb_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      ret_q <= ret_d;
      cnt_q <= cnt_d;
      if (idex_we) begin
        ex_load_v_q <= bus.id_valid_in & bus.id_is_load_in & ~idex_flush;
        ex_mem_v_q  <= bus.id_valid_in & bus.id_mem_op_in & ~idex_flush;
        ex_rd_q     <= bus.id_rd_in;
      end
      // ID slot is wrong-path exactly when IF/ID was last loaded with a squash bubble
      if (ifid_we | ifid_flush) begin
        ispb_q <= ifid_flush;
      end
      if (!pc_we && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNTW'(1);
      end
    end
  end

  // Combinational controls are forced low while reset is held
  always_comb begin
    bus.pc_we_out      = rst_n & pc_we;
    bus.pc_sel_br_out  = rst_n & pc_sel_br;
    bus.ifid_we_out    = rst_n & ifid_we;
    bus.ifid_flush_out = rst_n & ifid_flush;
    bus.idex_we_out    = rst_n & idex_we;
    bus.idex_flush_out = rst_n & idex_flush;
    bus.mem_req_out    = ex_mem_v_q;
    bus.ispb_out       = ispb_q;
    bus.stall_cnt_out  = stall_cnt_q;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random stimulus, all
// compared against a cycle-level behavioural model of the sequencing rules.
module tb_pipe_ctrl;
  localparam int unsigned REGAW    = 4;
  localparam int unsigned BR_FLUSH = 3;
  localparam int unsigned CNTW     = 8;
  localparam int          STALL_MAX = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  pipe_ctrl_if #(.REGAW(REGAW), .CNTW(CNTW)) bus ();

  pipe_ctrl #(.REGAW(REGAW), .BR_FLUSH(BR_FLUSH), .CNTW(CNTW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model state: what sits in EX, pending squash slots, wrong-path ID flag, stall count
  bit         m_ex_load, m_ex_mem, m_ispb;
  int         m_ex_rd, m_sq_left, m_stall;
  // Expected outputs for the current cycle
  bit e_pc_we, e_sel, e_ifid_we, e_ifid_fl, e_idex_we, e_idex_fl, e_req, e_ispb;
  int e_stall;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ex_load = 0; m_ex_mem = 0; m_ex_rd = 0; m_sq_left = 0; m_ispb = 0; m_stall = 0;
  endtask

  task automatic model_eval();
    bit busy, lu;
    {e_pc_we, e_sel, e_ifid_we, e_ifid_fl, e_idex_we, e_idex_fl} = '0;
    e_req = m_ex_mem; e_ispb = m_ispb; e_stall = m_stall;
    if (!rst_n) begin
      e_req = 0; e_ispb = 0; e_stall = 0;
      return;
    end
    busy = m_ex_mem && !bus.mem_ack_in;
    lu = bus.id_valid_in && m_ex_load &&
         ((bus.id_uses_rn_in && int'(bus.id_rn_in) == m_ex_rd) ||
          (bus.id_uses_rm_in && int'(bus.id_rm_in) == m_ex_rd));
    if (busy) begin
      // frozen: nothing moves
    end else if (m_sq_left > 0) begin
      e_pc_we = 1; e_ifid_we = 1; e_ifid_fl = 1; e_idex_we = 1;
    end else if (bus.id_ib_in && bus.id_valid_in) begin
      e_pc_we = 1; e_sel = 1; e_ifid_fl = 1; e_idex_we = 1;
    end else if (lu) begin
      e_idex_we = 1; e_idex_fl = 1;
    end else begin
      e_pc_we = 1; e_ifid_we = 1; e_idex_we = 1;
    end
  endtask

  // Apply the clock edge using the decisions from model_eval
  task automatic model_step();
    if (!rst_n) return;
    if (e_pc_we && m_sq_left > 0) m_sq_left--;
    else if (e_sel) m_sq_left = BR_FLUSH - 1;
    if (e_idex_we) begin
      m_ex_load = bus.id_valid_in && bus.id_is_load_in && !e_idex_fl;
      m_ex_mem  = bus.id_valid_in && bus.id_mem_op_in && !e_idex_fl;
      m_ex_rd   = int'(bus.id_rd_in);
    end
    if (e_ifid_we || e_ifid_fl) m_ispb = e_ifid_fl;
    if (!e_pc_we && m_stall < STALL_MAX) m_stall++;
  endtask

  task automatic check_outputs();
    check_eq("pc_we", bus.pc_we_out, e_pc_we);
    check_eq("pc_sel_br", bus.pc_sel_br_out, e_sel);
    check_eq("ifid_we", bus.ifid_we_out, e_ifid_we);
    check_eq("ifid_flush", bus.ifid_flush_out, e_ifid_fl);
    check_eq("idex_we", bus.idex_we_out, e_idex_we);
    check_eq("idex_flush", bus.idex_flush_out, e_idex_fl);
    check_eq("mem_req", bus.mem_req_out, e_req);
    check_eq("ispb", bus.ispb_out, e_ispb);
    check_eq("stall_cnt", bus.stall_cnt_out, e_stall);
  endtask

  task automatic drive_idle();
    bus.id_valid_in = 0; bus.id_rn_in = '0; bus.id_rm_in = '0; bus.id_uses_rn_in = 0;
    bus.id_uses_rm_in = 0; bus.id_rd_in = '0; bus.id_is_load_in = 0; bus.id_mem_op_in = 0;
    bus.id_ib_in = 0; bus.mem_ack_in = 1;
  endtask

  task automatic drive_alu(input int rd, input int rn, input int rm);
    drive_idle();
    bus.id_valid_in = 1; bus.id_rd_in = REGAW'(rd); bus.id_rn_in = REGAW'(rn);
    bus.id_rm_in = REGAW'(rm); bus.id_uses_rn_in = 1; bus.id_uses_rm_in = 1;
  endtask

  // Called just after a falling edge with inputs driven; returns after the next one
  task automatic cycle();
    #1;
    model_eval();
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst_n = 0;
    #1;
    model_reset();
    model_eval();
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  int s0, hi;

  initial begin
    drive_idle();
    model_reset();
    #2;
    model_eval();
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // Straight-line ALU ops
    for (int i = 0; i < 5; i++) begin
      drive_alu(i, i + 5, i + 9);
      cycle();
    end
    check_eq("t1_stall", bus.stall_cnt_out, 0);

    // Load then dependent add, then independent add
    drive_alu(3, 0, 0); bus.id_is_load_in = 1; bus.id_mem_op_in = 1; bus.id_uses_rn_in = 0;
    bus.id_uses_rm_in = 0;
    cycle();
    drive_alu(1, 3, 2);
    cycle();
    check_eq("t2_bubble_stall", bus.stall_cnt_out, 1);
    cycle();
    drive_alu(3, 0, 0); bus.id_is_load_in = 1; bus.id_mem_op_in = 1;
    cycle();
    drive_alu(1, 4, 2);
    cycle();
    check_eq("t2_nodep_stall", bus.stall_cnt_out, 1);

    // Taken branch: ispb must be high for BR_FLUSH cycles
    drive_idle(); bus.id_valid_in = 1; bus.id_ib_in = 1;
    cycle();
    drive_idle();
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.ispb_out) hi++;
      cycle();
    end
    check_eq("t3_ispb_len", hi, BR_FLUSH);

    // Store in EX, ack delayed 3 cycles, branch waiting in ID
    drive_idle(); bus.id_valid_in = 1; bus.id_mem_op_in = 1;
    cycle();
    s0 = int'(bus.stall_cnt_out);
    drive_idle(); bus.id_valid_in = 1; bus.id_ib_in = 1; bus.mem_ack_in = 0;
    for (int i = 0; i < 3; i++) cycle();
    bus.mem_ack_in = 1;
    #1;
    check_eq("t4_ack_branch", bus.pc_sel_br_out, 1);
    check_eq("t4_stall_delta", int'(bus.stall_cnt_out) - s0, 3);
    @(negedge clk);
    drive_idle();
    #1;
    model_step_skip: begin
      // the ack cycle above was observed by hand; re-sync the model through a reset
    end
    reset_pulse();

    // Reset pulse in the middle of a memory wait
    drive_idle(); bus.id_valid_in = 1; bus.id_mem_op_in = 1;
    cycle();
    drive_idle(); bus.mem_ack_in = 0;
    cycle();
    cycle();
    reset_pulse();
    drive_idle(); bus.mem_ack_in = 0;
    cycle();
    check_eq("t5_req_after_rst", bus.mem_req_out, 0);

    // Saturation of the stall counter
    drive_idle(); bus.id_valid_in = 1; bus.id_mem_op_in = 1;
    cycle();
    drive_idle(); bus.mem_ack_in = 0;
    for (int i = 0; i < (1 << CNTW) + 5; i++) cycle();
    check_eq("t6_saturated", bus.stall_cnt_out, STALL_MAX);
    reset_pulse();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      bus.id_valid_in   = ($urandom_range(0, 9) != 0);
      bus.id_rn_in      = REGAW'($urandom_range(0, 3));
      bus.id_rm_in      = REGAW'($urandom_range(0, 3));
      bus.id_rd_in      = REGAW'($urandom_range(0, 3));
      bus.id_uses_rn_in = 1'($urandom_range(0, 1));
      bus.id_uses_rm_in = 1'($urandom_range(0, 1));
      bus.id_is_load_in = ($urandom_range(0, 3) == 0);
      bus.id_mem_op_in  = bus.id_is_load_in | ($urandom_range(0, 5) == 0);
      bus.id_ib_in      = ($urandom_range(0, 7) == 0);
      bus.mem_ack_in    = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 299) == 0) reset_pulse();
      else cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
